// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants and read-stage occupancy type
package fifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } rd_occ_t;

endpackage

// File: rtl/fifo_rd_stage_if.sv
// rtl/fifo_rd_stage_if.sv - FIFO read port plus downstream valid/ready stream
interface fifo_rd_stage_if
  import fifo_pkg::*;
#(
  parameter int DW = DATA_WIDTH
);

  logic [DW-1:0] fifo_data_out;
  logic          fifo_empty;
  logic          read;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    input  fifo_data_out, fifo_empty, out_ready,
    output read, out_data, out_valid
  );

  modport slave (
    output fifo_data_out, fifo_empty, out_ready,
    input  read, out_data, out_valid
  );

endinterface

// File: rtl/rd_skid_buf.sv
// rtl/rd_skid_buf.sv - two-entry skid buffer holding head/tail and occupancy
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_head,
  output rd_occ_t               o_state
);

  rd_occ_t               r_state;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (i_flush) begin
      r_state <= S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (i_push) begin
            r_head  <= i_data;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (i_push && !i_pop) begin
            r_tail  <= i_data;
            r_state <= S_TWO;
          end else if (i_pop && !i_push) begin
            r_state <= S_EMPTY;
          end else if (i_push && i_pop) begin
            r_head  <= i_data;
          end
        end
        S_TWO: begin
          // push is gated off upstream while full, so only a pop can move us
          if (i_pop) begin
            r_head  <= r_tail;
            r_state <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_state = r_state;

endmodule

// File: rtl/fifo_rd_stage.sv
// rtl/fifo_rd_stage.sv - FIFO drain stage: read strobe, flush gating, delivered-word count
module fifo_rd_stage
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = fifo_pkg::DATA_WIDTH,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  fifo_rd_stage_if.master        bus,
  input  logic                   flush,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy
);

  rd_occ_t               w_state;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_push;
  logic                  w_pop;
  logic [COUNT_WIDTH-1:0] r_word_count;

  // read depends only on local state so out_ready never reaches the FIFO strobe
  assign w_push   = !reset && !bus.fifo_empty && !flush && (w_state != S_TWO);
  assign w_pop    = bus.out_valid && bus.out_ready;
  assign bus.read = w_push;

  rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.fifo_data_out),
    .o_head  (w_head),
    .o_state (w_state)
  );

  assign bus.out_data  = w_head;
  assign bus.out_valid = (w_state != S_EMPTY);
  assign busy          = bus.out_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_word_count <= '0;
    end else if (w_pop && !flush) begin
      r_word_count <= r_word_count + COUNT_WIDTH'(1);
    end
  end

  assign word_count = r_word_count;

endmodule

// File: tb/tb_fifo_rd_stage.sv
// tb/tb_fifo_rd_stage.sv - scoreboard bench for fifo_rd_stage against a FIFO model
module tb_fifo_rd_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        out_ready;
  logic [15:0] word_count;
  logic        busy;

  logic [7:0]  mem [256];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  sb_exp;
  int          n_cmp = 0;
  int          n_err = 0;

  fifo_rd_stage_if #(.DW(8)) bus ();

  assign bus.fifo_empty    = (rd_ptr == wr_ptr);
  assign bus.fifo_data_out = mem[rd_ptr[7:0]];
  assign bus.out_ready     = out_ready;

  fifo_rd_stage #(
    .DATA_WIDTH  (8),
    .COUNT_WIDTH (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .flush      (flush),
    .word_count (word_count),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.read) rd_ptr <= rd_ptr + 1;
  end

  always @(negedge clock) begin
    if (!reset && !flush && bus.out_valid && bus.out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_extra got %h required no word", bus.out_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (bus.out_data !== sb_exp) begin
          n_err++;
          $display("FAIL sb_data got %h required %h", bus.out_data, sb_exp);
        end
      end
    end
  end

  task push_word(input logic [7:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(d);
  endtask

  task apply_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    flush = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !bus.out_valid && bus.fifo_empty) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task feed(input int n);
    int pushed;
    pushed = 0;
    for (int c = 0; c < n + 1000 && pushed < n; c++) begin
      @(posedge clock);
      #1;
      while (wr_ptr - rd_ptr < 64 && pushed < n) begin
        push_word(8'(pushed ^ 8'h5C));
        pushed++;
      end
    end
  endtask

  task test_reset();
    bit ok;
    flush = 1'b0; out_ready = 1'b0; reset = 1'b0;
    #1 reset = 1'b1;
    #1 push_word(8'h5A);
    #1;
    n_cmp++; if (bus.read !== 1'b0) begin n_err++; $display("FAIL rst_read got %b required 0", bus.read); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b required 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL rst_data got %h required 00", bus.out_data); end
    n_cmp++; if (word_count !== 16'h0000) begin n_err++; $display("FAIL rst_count got %h required 0000", word_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b required 0", busy); end
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (bus.read !== 1'b1) begin n_err++; $display("FAIL rst_first_read got %b required 1", bus.read); end
    out_ready = 1'b1;
    wait_drain(10, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rst_drain got %b required 1", ok); end
  endtask

  task test_streaming();
    logic [7:0] tab [4];
    bit ok;
    tab = '{8'h11, 8'h22, 8'h33, 8'h44};
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(tab[i]);
    @(negedge clock);
    n_cmp++; if (bus.read !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL str_lat got read=%b valid=%b required read=1 valid=0", bus.read, bus.out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== tab[i]) begin
        n_err++; $display("FAIL str_word%0d got valid=%b data=%h required valid=1 data=%h", i, bus.out_valid, bus.out_data, tab[i]);
      end
    end
    @(negedge clock);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL str_idle got %b required 0", bus.out_valid); end
    n_cmp++; if (word_count !== 16'd4) begin n_err++; $display("FAIL str_count got %0d required 4", word_count); end
    wait_drain(10, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL str_drain got %b required 1", ok); end
  endtask

  task test_backpressure();
    int base;
    bit ok;
    apply_reset();
    out_ready = 1'b0;
    base = rd_ptr;
    for (int i = 0; i < 6; i++) push_word(8'hA0 + 8'(i));
    repeat (5) @(negedge clock);
    n_cmp++; if (rd_ptr - base !== 2) begin n_err++; $display("FAIL bp_pops got %0d required 2", rd_ptr - base); end
    n_cmp++; if (bus.read !== 1'b0) begin n_err++; $display("FAIL bp_read got %b required 0", bus.read); end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA0) begin
      n_err++; $display("FAIL bp_hold got valid=%b data=%h required valid=1 data=a0", bus.out_valid, bus.out_data);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.read !== 1'b0) begin n_err++; $display("FAIL bp_read_full got %b required 0", bus.read); end
    @(negedge clock);
    n_cmp++; if (bus.read !== 1'b1 || bus.out_data !== 8'hA1) begin
      n_err++; $display("FAIL bp_resume got read=%b data=%h required read=1 data=a1", bus.read, bus.out_data);
    end
    wait_drain(20, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL bp_drain got %b required 1", ok); end
    n_cmp++; if (word_count !== 16'd6) begin n_err++; $display("FAIL bp_count got %0d required 6", word_count); end
  endtask

  task test_flush();
    int base;
    bit ok;
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(8'hB0 + 8'(i));
    repeat (4) @(negedge clock);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.read !== 1'b0) begin
      n_err++; $display("FAIL fl_full got valid=%b read=%b required valid=1 read=0", bus.out_valid, bus.read);
    end
    @(posedge clock);
    #1 flush = 1'b1;
    out_ready = 1'b1;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    base = rd_ptr;
    #1;
    n_cmp++; if (bus.read !== 1'b0) begin n_err++; $display("FAIL fl_read got %b required 0", bus.read); end
    @(posedge clock);
    #1 flush = 1'b0;
    n_cmp++; if (rd_ptr !== base) begin n_err++; $display("FAIL fl_nopop got %0d required %0d", rd_ptr, base); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid got %b required 0", bus.out_valid); end
    n_cmp++; if (word_count !== 16'd0) begin n_err++; $display("FAIL fl_count got %0d required 0", word_count); end
    wait_drain(10, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL fl_drain got %b required 1", ok); end
    n_cmp++; if (word_count !== 16'd1) begin n_err++; $display("FAIL fl_after got %0d required 1", word_count); end
  endtask

  task test_counter_wrap();
    bit ok;
    apply_reset();
    out_ready = 1'b1;
    feed(65535);
    wait_drain(300, ok);
    n_cmp++; if (ok !== 1'b1 || word_count !== 16'hFFFF) begin
      n_err++; $display("FAIL wrap_ffff got ok=%b count=%h required ok=1 count=ffff", ok, word_count);
    end
    feed(1);
    wait_drain(20, ok);
    n_cmp++; if (ok !== 1'b1 || word_count !== 16'h0000) begin
      n_err++; $display("FAIL wrap_0000 got ok=%b count=%h required ok=1 count=0000", ok, word_count);
    end
    feed(1);
    wait_drain(20, ok);
    n_cmp++; if (ok !== 1'b1 || word_count !== 16'h0001) begin
      n_err++; $display("FAIL wrap_0001 got ok=%b count=%h required ok=1 count=0001", ok, word_count);
    end
  endtask

  task test_reset_mid_burst();
    int base;
    bit ok;
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'hC0 + 8'(i));
    repeat (4) @(negedge clock);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC0) begin
      n_err++; $display("FAIL mr_pre got valid=%b data=%h required valid=1 data=c0", bus.out_valid, bus.out_data);
    end
    base = rd_ptr;
    #3 reset = 1'b1;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mr_valid got valid=%b busy=%b required 0/0", bus.out_valid, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_cmp++; if (bus.read !== 1'b0) begin n_err++; $display("FAIL mr_read%0d got %b required 0", i, bus.read); end
    end
    n_cmp++; if (rd_ptr !== base) begin n_err++; $display("FAIL mr_ptr got %0d required %0d", rd_ptr, base); end
    @(posedge clock);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    wait_drain(20, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL mr_drain got %b required 1", ok); end
    n_cmp++; if (word_count !== 16'd2) begin n_err++; $display("FAIL mr_count got %0d required 2", word_count); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_counter_wrap();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
